// File: rtl/word_shifter_if.sv
// Bundle of load handshake, shift control and serial/parallel result signals
// for word_shifter.
interface word_shifter_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 1
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             shift;
   logic             abort;
   logic [LANES-1:0] in;
   logic [LANES-1:0] out;
   logic [WIDTH-1:0] current_data;
   logic             busy;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;

   modport master (
      output load_valid, load_data, shift, abort, in,
      input  load_ready, out, current_data, busy, rx_valid, rx_data
   );

   modport slave (
      input  load_valid, load_data, shift, abort, in,
      output load_ready, out, current_data, busy, rx_valid, rx_data
   );
endinterface

// File: rtl/word_shifter.sv
// Framed shift engine: loads a word, shifts it out LANES bits per enabled step
// while shifting new bits in, and strobes the captured word after WIDTH/LANES steps.
module word_shifter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LANES     = 1,
   parameter bit          MSB_FIRST = 1'b0
) (
   input logic           clk,
   input logic           reset,
   word_shifter_if.slave bus
);

   localparam int unsigned Steps = WIDTH / LANES;
   localparam int unsigned CntW  = $clog2(Steps) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

   typedef enum logic [0:0] {StIdle, StShifting} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0] shifted;
   logic             final_step;
   logic             load_fire;

   generate
      if (WIDTH == LANES) begin : g_whole
         assign shifted = bus.in;
         assign bus.out = data_q;
      end else if (MSB_FIRST) begin : g_msb
         assign shifted = {data_q[WIDTH-LANES-1:0], bus.in};
         assign bus.out = data_q[WIDTH-1 -: LANES];
      end else begin : g_lsb
         assign shifted = {bus.in, data_q[WIDTH-1:LANES]};
         assign bus.out = data_q[LANES-1:0];
      end
   endgenerate

   assign final_step     = (state_q == StShifting) && bus.shift && (cnt_q == LastCnt);
   assign bus.load_ready = (state_q == StIdle) || (final_step && !bus.abort);
   assign load_fire      = bus.load_valid && bus.load_ready;

   assign bus.current_data = data_q;
   assign bus.busy         = (state_q == StShifting);
   assign bus.rx_valid     = rx_valid_q;
   assign bus.rx_data      = rx_data_q;

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      if (bus.abort) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if ((state_q == StShifting) && bus.shift) begin
         data_d = shifted;
         cnt_d  = cnt_q + 1'b1;
         if (final_step) begin
            rx_data_d  = shifted;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
            cnt_d      = '0;
         end
      end

      // A completed handshake is never dropped; with abort it can only happen from idle.
      if (load_fire) begin
         data_d  = bus.load_data;
         cnt_d   = '0;
         state_d = StShifting;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         data_q     <= '0;
         cnt_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

endmodule

// File: tb/tb_word_shifter.sv
// Drives an LSB-first 1-lane and an MSB-first 2-lane word_shifter in lockstep
// and compares both against a frame-level reference model.
module tb_word_shifter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   word_shifter_if #(.WIDTH(8), .LANES(1)) if0 ();
   word_shifter_if #(.WIDTH(8), .LANES(2)) if1 ();

   word_shifter #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave)
   );
   word_shifter #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1.slave)
   );

   int unsigned vecs = 0;
   int unsigned miscompares = 0;

   // Reference model: index 0 = LSB-first/1 lane, index 1 = MSB-first/2 lanes.
   int unsigned m_data[2];
   int unsigned m_left[2];
   int unsigned m_rxd[2];
   bit          m_busy[2];
   bit          m_rxv[2];

   function automatic int unsigned lanes(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int unsigned mshift(int d, int unsigned w, int unsigned inb);
      if (d == 1) return ((w << lanes(d)) | inb) & 32'hFF;
      return (w >> lanes(d)) | (inb << (8 - lanes(d)));
   endfunction

   function automatic int unsigned exp_out(int d);
      if (d == 1) return m_data[d] >> (8 - lanes(d));
      return m_data[d] & ((32'd1 << lanes(d)) - 1);
   endfunction

   function automatic int unsigned exp_ready(int d, bit sh, bit ab);
      return (!m_busy[d] || (sh && m_left[d] == 1 && !ab)) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_data[d] = 0; m_left[d] = 0; m_rxd[d] = 0; m_busy[d] = 0; m_rxv[d] = 0;
      end
   endtask

   task automatic model_edge(int d, bit lv, int unsigned ld, bit sh, bit ab, int unsigned inb);
      bit rdy;
      bit nv;
      rdy = exp_ready(d, sh, ab) != 0;
      nv  = 0;
      if (ab) begin
         m_busy[d] = 0;
      end else if (m_busy[d] && sh) begin
         m_data[d] = mshift(d, m_data[d], inb);
         m_left[d] = m_left[d] - 1;
         if (m_left[d] == 0) begin
            m_rxd[d]  = m_data[d];
            nv        = 1;
            m_busy[d] = 0;
         end
      end
      if (lv && rdy) begin
         m_data[d] = ld;
         m_busy[d] = 1;
         m_left[d] = 8 / lanes(d);
      end
      m_rxv[d] = nv;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string p, input int d, input bit sh, input bit ab,
                          input logic [31:0] rdy, input logic [31:0] o,
                          input logic [31:0] cd, input logic [31:0] bz,
                          input logic [31:0] rv, input logic [31:0] rd);
      chk({p, ".load_ready"}, rdy, exp_ready(d, sh, ab));
      chk({p, ".out"}, o, exp_out(d));
      chk({p, ".current_data"}, cd, m_data[d]);
      chk({p, ".busy"}, bz, 32'(m_busy[d]));
      chk({p, ".rx_valid"}, rv, 32'(m_rxv[d]));
      chk({p, ".rx_data"}, rd, m_rxd[d]);
   endtask

   task automatic drive(bit lv, logic [7:0] ld, bit sh, bit ab, logic in0, logic [1:0] in1);
      if0.load_valid = lv; if0.load_data = ld; if0.shift = sh; if0.abort = ab; if0.in = in0;
      if1.load_valid = lv; if1.load_data = ld; if1.shift = sh; if1.abort = ab; if1.in = in1;
   endtask

   // One clock: drive, check combinational/held state, clock it, advance the model.
   task automatic cyc(bit lv, logic [7:0] ld, bit sh, bit ab, logic in0, logic [1:0] in1);
      drive(lv, ld, sh, ab, in0, in1);
      #1;
      chk_dut("d0", 0, sh, ab, 32'(if0.load_ready), 32'(if0.out), 32'(if0.current_data),
              32'(if0.busy), 32'(if0.rx_valid), 32'(if0.rx_data));
      chk_dut("d1", 1, sh, ab, 32'(if1.load_ready), 32'(if1.out), 32'(if1.current_data),
              32'(if1.busy), 32'(if1.rx_valid), 32'(if1.rx_data));
      @(posedge clk);
      model_edge(0, lv, ld, sh, ab, in0);
      model_edge(1, lv, ld, sh, ab, in1);
      #1;
   endtask

   task automatic shift_rand(int n);
      for (int i = 0; i < n; i++)
         cyc(0, 8'h00, 1, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
   endtask

   // Asynchronous reset asserted between edges, checked before the next edge.
   task automatic do_reset();
      drive(0, 8'h00, 0, 0, 0, 2'b00);
      #2 reset = 1'b1;
      #1;
      chk("rst.d0.current_data", 32'(if0.current_data), 0);
      chk("rst.d0.rx_data", 32'(if0.rx_data), 0);
      chk("rst.d0.busy", 32'(if0.busy), 0);
      chk("rst.d0.rx_valid", 32'(if0.rx_valid), 0);
      chk("rst.d1.current_data", 32'(if1.current_data), 0);
      chk("rst.d1.busy", 32'(if1.busy), 0);
      model_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst.d0.load_ready", 32'(if0.load_ready), 1);
      chk("rst.d1.load_ready", 32'(if1.load_ready), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] a5;
      logic [7:0] x3c;
      logic [1:0] mo[4];
      logic [1:0] mi[4];
      int         cnt;
      int unsigned held;
      a5  = 8'hA5;
      x3c = 8'h3C;
      mo  = '{2'b11, 2'b00, 2'b01, 2'b10};
      mi  = '{2'b01, 2'b10, 2'b11, 2'b00};

      model_reset();
      reset = 1'b1;
      drive(0, 8'h00, 0, 0, 0, 2'b00);
      #1;
      chk("init.d0.current_data", 32'(if0.current_data), 0);
      chk("init.d0.load_ready", 32'(if0.load_ready), 1);
      chk("init.d0.busy", 32'(if0.busy), 0);
      chk("init.d0.rx_valid", 32'(if0.rx_valid), 0);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic LSB-first frame on dut0.
      cyc(1, 8'hA5, 0, 0, 0, 2'b00);
      for (int i = 0; i < 8; i++) begin
         chk("lsb.out_seq", 32'(if0.out), 32'(a5[i]));
         cyc(0, 8'h00, 1, 0, x3c[i], 2'($urandom_range(0, 3)));
      end
      chk("lsb.rx_valid", 32'(if0.rx_valid), 1);
      chk("lsb.rx_data", 32'(if0.rx_data), 32'h3C);
      chk("lsb.busy_after", 32'(if0.busy), 0);
      cyc(0, 8'h00, 0, 0, 0, 2'b00);
      chk("lsb.rx_valid_drop", 32'(if0.rx_valid), 0);

      // MSB-first 2-lane frame on dut1.
      cyc(1, 8'hC6, 0, 0, 0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         chk("msb.out_seq", 32'(if1.out), 32'(mo[i]));
         cyc(0, 8'h00, 1, 0, 1'($urandom_range(0, 1)), mi[i]);
      end
      chk("msb.rx_valid", 32'(if1.rx_valid), 1);
      chk("msb.rx_data", 32'(if1.rx_data), 32'h6C);
      shift_rand(4);

      // Back-to-back: reload on the final shift edge of dut0.
      cyc(1, 8'h5A, 0, 0, 0, 2'b00);
      shift_rand(7);
      cyc(1, 8'h12, 1, 0, 1, 2'b01);
      chk("b2b.current_data", 32'(if0.current_data), 32'h12);
      chk("b2b.busy", 32'(if0.busy), 1);
      chk("b2b.rx_valid", 32'(if0.rx_valid), 1);
      shift_rand(7);
      chk("b2b.busy_before_last", 32'(if0.busy), 1);
      shift_rand(1);
      chk("b2b.second_rx_valid", 32'(if0.rx_valid), 1);

      // Stalled frame: shift enabled on one edge out of three.
      cyc(1, 8'h3E, 0, 0, 0, 2'b00);
      cnt = 0;
      for (int k = 0; k < 40 && cnt < 8; k++) begin
         cyc(0, 8'h00, (k % 3) == 0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         if ((k % 3) == 0) cnt++;
      end
      chk("stall.rx_valid", 32'(if0.rx_valid), 1);
      held = m_data[0];
      for (int k = 0; k < 3; k++) cyc(0, 8'h00, 1, 0, 1, 2'b11);
      chk("idle.current_data", 32'(if0.current_data), held);

      // Abort after 3 shifts with a load offered in the same cycle.
      cyc(1, 8'h96, 0, 0, 0, 2'b00);
      shift_rand(3);
      held = m_data[0];
      cyc(1, 8'hFF, 1, 1, 1, 2'b10);
      chk("abort.busy", 32'(if0.busy), 0);
      chk("abort.rx_valid", 32'(if0.rx_valid), 0);
      chk("abort.current_data", 32'(if0.current_data), held);
      drive(0, 8'h00, 0, 0, 0, 2'b00);
      #1;
      chk("abort.load_ready_after", 32'(if0.load_ready), 1);
      cyc(0, 8'h00, 0, 0, 0, 2'b00);

      // Reset mid-frame after 5 shifts.
      cyc(1, 8'h77, 0, 0, 0, 2'b00);
      shift_rand(5);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/word_shifter.md
# word_shifter

Parametrised framed shift engine, the successor to the single-bit shift register in the test harness. It loads a parallel word through a valid/ready handshake and shifts it out LANES bits per enable, LSB- or MSB-first. At the same time it shifts in the same number of bits. After WIDTH/LANES steps it presents the captured word with a one-cycle strobe. It sits between the harness sequencers and serial delay-line ports, and replaces hand-counted shift sequences.

## Interface
- WIDTH, 8, word width in bits; must be a multiple of LANES.
- LANES, 1, bits shifted per step (serial lane count).
- MSB_FIRST, 0, 0 = shift toward bit 0 (LSB out first), 1 = shift toward bit WIDTH-1 (MSB out first).
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  parallel word offered.
- load_ready  output  1  word can be accepted this cycle (combinational).
- load_data  input  WIDTH  parallel word.
- shift  input  1  shift-step enable.
- abort  input  1  synchronous frame abort.
- in  input  LANES  serial bits shifted in.
- out  output  LANES  serial bits shifted out (combinational from data).
- current_data  output  WIDTH  live shift register contents.
- busy  output  1  high in SHIFTING.
- rx_valid  output  1  one-cycle strobe: rx_data holds a completed word.
- rx_data  output  WIDTH  last completed captured word.

## Operation
- STEPS = WIDTH/LANES. Step counter cnt runs 0..STEPS-1 and is sized $clog2(STEPS)+1.
- States:
  - IDLE: shift is ignored.
  - SHIFTING: each shift step advances cnt.
- Reset (async) sets:
  - data = 0, cnt = 0, state = IDLE.
  - rx_data = 0, rx_valid = 0, busy = 0.
  - load_ready therefore reads 1.
- load_ready = IDLE, or (SHIFTING and shift and cnt == STEPS-1 and !abort).
- Load (load_valid & load_ready) sets data <= load_data, cnt <= 0, state <= SHIFTING.
- Shift step, LSB-first: data <= {in, data[WIDTH-1:LANES]}; out = data[LANES-1:0].
- Shift step, MSB-first: data <= {data[WIDTH-LANES-1:0], in}; out = data[WIDTH-1 -: LANES].
- Final step (cnt == STEPS-1 and shift):
  - rx_data <= post-shift word.
  - rx_valid <= 1 for the next cycle only.
  - state <= IDLE, unless a load is accepted on the same edge.
- Simultaneous final shift and load:
  - rx_data captures the shifted word and rx_valid pulses.
  - data <= load_data, cnt <= 0, state stays SHIFTING.
  - This gives back-to-back frames with no gap cycle.
- Priority: reset > abort > final-shift/load > shift.
- abort:
  - state <= IDLE, cnt <= 0, no rx_valid.
  - data is retained.
  - A load offered in the same cycle is refused (load_ready low).
- In IDLE, out and current_data reflect held data; shift has no effect.
- rx_valid is a pulse with no backpressure; rx_data holds until the next completed frame.

## Timing
- Load to first out valid: 0 cycles after the load edge; out shows the first lane the cycle after the handshake.
- A frame takes exactly STEPS shift-enabled edges; gaps in shift stall the frame indefinitely.
- rx_valid is high during the cycle after the final-shift edge; rx_data is valid from that same edge.
- busy falls on the final-shift edge, unless reloaded.
- Reset asserted mid-frame clears everything immediately; no rx_valid follows.

## Test plan
- **Basic LSB-first:** WIDTH=8, LANES=1, MSB_FIRST=0. Load 0xA5, then 8 consecutive shifts with in = bits of 0x3C LSB-first.
  - out sequence 1,0,1,0,0,1,0,1.
  - rx_data = 0x3C, rx_valid high for exactly one cycle, busy low after.
- **MSB-first multi-lane:** WIDTH=8, LANES=2, MSB_FIRST=1. Load 0xC6, then 4 shifts with in = 2'b01,2'b10,2'b11,2'b00.
  - out = 2'b11,2'b00,2'b01,2'b10.
  - rx_data = 0x6C after 4 steps.
- **Back-to-back frames:** load 0x12 in the same cycle as the final shift of the previous frame.
  - rx_valid pulses.
  - current_data = 0x12 next cycle, busy stays high, cnt restarts.
  - Second frame completes after 8 more shifts.
- **Stalls and ignored shifts:** shift toggling 1,0,0,1,... during a frame gives completion after exactly 8 enabled edges. shift pulses while IDLE leave current_data unchanged.
- **Abort mid-frame:** assert abort after 3 shifts.
  - busy low, no rx_valid, current_data retains the partially shifted value.
  - load_ready low during the abort cycle and high on the following cycle.
- **Reset mid-frame:** assert reset asynchronously (between edges) after 5 shifts.
  - current_data = 0, rx_data = 0, busy = 0, rx_valid = 0 immediately.
  - load_ready = 1 after release.
